// File: rtl/rom_16.sv
// Twiddle-factor ROM for the 16-point stage of the 32-point MDC FFT.
// A valid_in strobe starts a 16-cycle burst of W32^k, k = 0..15, in Q1.7.
module rom_16 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    output logic [8:0] w_r,
    output logic [8:0] w_i,
    output logic       valid_out_rom16
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q;
    logic [3:0] k_q;
    logic [3:0] k_d;
    logic [8:0] tab_r;
    logic [8:0] tab_i;

    // Index of the entry to register on this edge: a strobe always wins.
    always_comb begin
        k_d = valid_in ? '0 : k_q + 4'd1;
        tab_r = '0;
        tab_i = '0;
        case (k_d)
            4'd0:  begin tab_r = 9'h080; tab_i = 9'h000; end
            4'd1:  begin tab_r = 9'h07E; tab_i = 9'h1E7; end
            4'd2:  begin tab_r = 9'h076; tab_i = 9'h1CF; end
            4'd3:  begin tab_r = 9'h06A; tab_i = 9'h1B9; end
            4'd4:  begin tab_r = 9'h05B; tab_i = 9'h1A5; end
            4'd5:  begin tab_r = 9'h047; tab_i = 9'h196; end
            4'd6:  begin tab_r = 9'h031; tab_i = 9'h18A; end
            4'd7:  begin tab_r = 9'h019; tab_i = 9'h182; end
            4'd8:  begin tab_r = 9'h000; tab_i = 9'h180; end
            4'd9:  begin tab_r = 9'h1E7; tab_i = 9'h182; end
            4'd10: begin tab_r = 9'h1CF; tab_i = 9'h18A; end
            4'd11: begin tab_r = 9'h1B9; tab_i = 9'h196; end
            4'd12: begin tab_r = 9'h1A5; tab_i = 9'h1A5; end
            4'd13: begin tab_r = 9'h196; tab_i = 9'h1B9; end
            4'd14: begin tab_r = 9'h18A; tab_i = 9'h1CF; end
            4'd15: begin tab_r = 9'h182; tab_i = 9'h1E7; end
            default: begin tab_r = '0; tab_i = '0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q         <= IDLE;
            k_q             <= '0;
            w_r             <= '0;
            w_i             <= '0;
            valid_out_rom16 <= 1'b0;
        end else if (valid_in || (state_q == RUN && k_q != 4'd15)) begin
            state_q         <= RUN;
            k_q             <= k_d;
            w_r             <= tab_r;
            w_i             <= tab_i;
            valid_out_rom16 <= 1'b1;
        end else begin
            state_q         <= IDLE;
            k_q             <= '0;
            w_r             <= '0;
            w_i             <= '0;
            valid_out_rom16 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_16.sv
// Scoreboard bench for rom_16: expected twiddles are derived from cos/sin and
// the cycle distance to the most recent strobe.
module tb_rom_16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic [8:0] w_r;
    logic [8:0] w_i;
    logic       valid_out_rom16;

    rom_16 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .w_r             (w_r),
        .w_i             (w_i),
        .valid_out_rom16 (valid_out_rom16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int i;
        bit v;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    bit   have_strobe = 1'b0;
    int   run_len = 0;
    int   max_run = 0;

    function automatic int rnd(real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int ref_r(int k);
        return rnd(128.0 * $cos(2.0 * 3.14159265358979 * k / 32.0));
    endfunction

    function automatic int ref_i(int k);
        return rnd(-128.0 * $sin(2.0 * 3.14159265358979 * k / 32.0));
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock edge: apply valid_in, then push what the outputs must show.
    task automatic cycle(bit v);
        exp_t e;
        int   k;
        valid_in = v;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            have_strobe = 1'b0;
        end else if (v) begin
            have_strobe = 1'b1;
            last_strobe = cyc;
        end
        k = cyc - last_strobe;
        e.cyc = cyc;
        if (have_strobe && k < 16) begin
            e.r = ref_r(k);
            e.i = ref_i(k);
            e.v = 1'b1;
        end else begin
            e.r = 0;
            e.i = 0;
            e.v = 1'b0;
        end
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) cycle(1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("w_r", $signed(w_r), e.r);
            check("w_i", $signed(w_i), e.i);
            check("valid_out", int'(valid_out_rom16), int'(e.v));
            run_len = valid_out_rom16 ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    initial begin
        rst_n    = 1'b1;
        valid_in = 1'b0;
        #1;
        check("reset_w_r", int'(w_r), 0);
        check("reset_valid", int'(valid_out_rom16), 0);
        cycle(1'b0);
        rst_n = 1'b0;
        idle(24);

        // Single burst followed by return to idle.
        cycle(1'b1);
        idle(20);

        // Spaced strobes: 28 then 71 cycles apart.
        cycle(1'b1);
        idle(27);
        cycle(1'b1);
        idle(70);
        cycle(1'b1);
        idle(20);

        // Mid-burst restart five cycles after the first strobe.
        max_run = 0;
        cycle(1'b1);
        idle(4);
        cycle(1'b1);
        idle(20);
        check("restart_run_len", max_run, 21);

        // Asynchronous reset at k = 7, strobe ignored while in reset.
        cycle(1'b1);
        idle(7);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("async_rst_w_r", int'(w_r), 0);
        check("async_rst_w_i", int'(w_i), 0);
        check("async_rst_valid", int'(valid_out_rom16), 0);
        cycle(1'b1);
        cycle(1'b0);
        rst_n = 1'b0;
        idle(5);
        cycle(1'b1);
        idle(20);

        // Boundary strobe on the retiring edge gives 32 contiguous cycles.
        max_run = 0;
        cycle(1'b1);
        idle(15);
        cycle(1'b1);
        idle(20);
        check("boundary_run_len", max_run, 32);

        // Multi-cycle strobe holds entry 0.
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        idle(20);

        // Random strobes.
        for (int j = 0; j < 400; j++) cycle($urandom_range(0, 11) == 0);
        idle(20);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
